// File: rtl/countdown_timer_n.sv
// countdown_timer_n
// N-digit BCD countdown clock with start/pause control, bonus-time insertion,
// a warning blink window and active-low 7-segment outputs.
// The count is held in BCD throughout, so the display path needs no binary
// to BCD conversion and the borrow/carry chains stay one digit wide.
module countdown_timer_n #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TICK_HZ    = 1,
  parameter int DIGITS     = 2,
  parameter int START_SECS = 60,
  parameter int BONUS_SECS = 5,
  parameter int WARN_SECS  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  bonus,
  output logic [7*DIGITS-1:0]   hex,
  output logic [4*DIGITS-1:0]   value_bcd,
  output logic                  game_over_signal,
  output logic                  expired_pulse
);

  // Tick divider geometry: the divider runs 0..DIV-1, the blink phase flips
  // at the half-way point and at the wrap.
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int DW      = $clog2(DIV);
  localparam int MAX_VAL = 10 ** DIGITS - 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(DIV / 2 - 1);

  // Constants larger than the display can hold are clamped to the maximum:
  // a clamped bonus still saturates to the same result, and a clamped warning
  // threshold still covers every displayable value.
  localparam int BONUS_CLAMP = (BONUS_SECS > MAX_VAL) ? MAX_VAL : BONUS_SECS;
  localparam int WARN_CLAMP  = (WARN_SECS  > MAX_VAL) ? MAX_VAL : WARN_SECS;

  // Elaboration-time binary to packed BCD conversion, digit 0 = units.
  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    int                  rem;
    logic [4*DIGITS-1:0] r;
    rem = v;
    r   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(rem % 10);
      rem         = rem / 10;
    end
    return r;
  endfunction

  localparam logic [4*DIGITS-1:0] START_BCD = to_bcd(START_SECS);
  localparam logic [4*DIGITS-1:0] BONUS_BCD = to_bcd(BONUS_CLAMP);
  localparam logic [4*DIGITS-1:0] WARN_BCD  = to_bcd(WARN_CLAMP);
  localparam logic [4*DIGITS-1:0] MAX_BCD   = to_bcd(MAX_VAL);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSED  = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  state_t              state_reg;
  logic [DW-1:0]       div_reg;
  logic                blink_reg;
  logic [4*DIGITS-1:0] value_reg;
  logic                game_over_reg;
  logic                expired_pulse_reg;

  logic                div_last;
  logic                div_half;
  logic                tick;
  logic                expire_now;
  logic                warn_zone;
  logic                blank;
  logic [4*DIGITS-1:0] dec_value;
  logic [4*DIGITS-1:0] bonus_base;
  logic [4*DIGITS-1:0] add_value;
  logic [4*DIGITS-1:0] bonus_value;
  logic [DIGITS-1:0]   borrow_chain;
  logic [DIGITS:0]     carry_chain;

  assign div_last = (div_reg == DIV_LAST);
  assign div_half = (div_reg == DIV_HALF);
  assign tick     = (state_reg == S_RUN) && div_last;

  // Bonus is added on top of the decremented value when both land in the
  // same cycle, so a bonus on the final tick rescues the player.
  assign bonus_base  = tick ? dec_value : value_reg;
  assign bonus_value = carry_chain[DIGITS] ? MAX_BCD : add_value;
  assign expire_now  = tick && !bonus && (dec_value == '0);

  // Packed BCD compares correctly as an unsigned binary number.
  assign warn_zone = (value_reg <= WARN_BCD);
  assign blank     = !blink_reg &&
                     ((state_reg == S_EXPIRED) || ((state_reg == S_RUN) && warn_zone));

  assign borrow_chain[0] = 1'b1;
  assign carry_chain[0]  = 1'b0;

  // Per-digit slice: decrement borrow chain, bonus add carry chain and the
  // segment encoder for that digit.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic [3:0] cur_digit;
    logic [4:0] digit_sum;
    logic [6:0] seg_code;

    assign cur_digit = value_reg[4*gi +: 4];

    assign dec_value[4*gi +: 4] = (borrow_chain[gi] && (cur_digit == 4'd0)) ?
                                  4'd9 : (cur_digit - {3'b000, borrow_chain[gi]});

    if (gi < DIGITS - 1) begin : g_borrow
      assign borrow_chain[gi+1] = borrow_chain[gi] && (cur_digit == 4'd0);
    end

    assign digit_sum = {1'b0, bonus_base[4*gi +: 4]} +
                       {1'b0, BONUS_BCD[4*gi +: 4]} +
                       {4'b0000, carry_chain[gi]};
    assign carry_chain[gi+1]    = (digit_sum > 5'd9);
    assign add_value[4*gi +: 4] = carry_chain[gi+1] ? 4'(digit_sum - 5'd10) : digit_sum[3:0];

    // Active-low segment lookup, bit0 = a ... bit6 = g.
    always_comb begin
      seg_code = 7'b1111111;
      case (cur_digit)
        4'd0: seg_code = 7'b1000000;
        4'd1: seg_code = 7'b1111001;
        4'd2: seg_code = 7'b0100100;
        4'd3: seg_code = 7'b0110000;
        4'd4: seg_code = 7'b0011001;
        4'd5: seg_code = 7'b0010010;
        4'd6: seg_code = 7'b0000010;
        4'd7: seg_code = 7'b1111000;
        4'd8: seg_code = 7'b0000000;
        4'd9: seg_code = 7'b0010000;
        default: seg_code = 7'b1111111;
      endcase
    end

    assign hex[7*gi +: 7] = blank ? 7'b1111111 : seg_code;
  end

  // Timer state machine: state, divider, blink phase, count and flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg         <= S_IDLE;
      div_reg           <= '0;
      blink_reg         <= 1'b1;
      value_reg         <= START_BCD;
      game_over_reg     <= 1'b0;
      expired_pulse_reg <= 1'b0;
    end else begin
      expired_pulse_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg <= S_RUN;
            div_reg   <= '0;
            blink_reg <= 1'b1;
          end
        end

        S_RUN: begin
          div_reg <= div_last ? '0 : (div_reg + DW'(1));
          if (div_last || div_half) begin
            blink_reg <= ~blink_reg;
          end
          if (bonus) begin
            value_reg <= bonus_value;
          end else if (tick) begin
            value_reg <= dec_value;
          end
          // Reaching zero wins over a simultaneous pause request.
          if (expire_now) begin
            state_reg         <= S_EXPIRED;
            game_over_reg     <= 1'b1;
            expired_pulse_reg <= 1'b1;
          end else if (pause) begin
            state_reg <= S_PAUSED;
          end
        end

        S_PAUSED: begin
          if (start) begin
            state_reg <= S_RUN;
            value_reg <= START_BCD;
            div_reg   <= '0;
            blink_reg <= 1'b1;
          end else begin
            if (bonus) begin
              value_reg <= bonus_value;
            end
            // Divider was frozen while paused; resume from where it stopped.
            if (pause) begin
              state_reg <= S_RUN;
              blink_reg <= 1'b1;
            end
          end
        end

        S_EXPIRED: begin
          // Divider keeps running so the zero display keeps blinking.
          div_reg <= div_last ? '0 : (div_reg + DW'(1));
          if (div_last || div_half) begin
            blink_reg <= ~blink_reg;
          end
          if (start) begin
            state_reg     <= S_RUN;
            value_reg     <= START_BCD;
            div_reg       <= '0;
            game_over_reg <= 1'b0;
          end
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign value_bcd        = value_reg;
  assign game_over_signal = game_over_reg;
  assign expired_pulse    = expired_pulse_reg;

endmodule

// File: tb/tb_countdown_timer_n.sv
// tb_countdown_timer_n
// Scoreboard bench: each observation point pushes the expected count, flags
// and blanking before the stimulus is applied, then pops and compares once
// the DUT has had the stated number of clock edges.
module tb_countdown_timer_n;

  localparam int DIGITS = 2;

  logic                clk;
  logic                rst;
  logic                start;
  logic                pause;
  logic                bonus;
  logic [7*DIGITS-1:0] hex;
  logic [4*DIGITS-1:0] value_bcd;
  logic                game_over_signal;
  logic                expired_pulse;

  countdown_timer_n #(
    .CLK_HZ     (8),
    .TICK_HZ    (1),
    .DIGITS     (DIGITS),
    .START_SECS (12),
    .BONUS_SECS (5),
    .WARN_SECS  (3)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .pause            (pause),
    .bonus            (bonus),
    .hex              (hex),
    .value_bcd        (value_bcd),
    .game_over_signal (game_over_signal),
    .expired_pulse    (expired_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] value;
    logic       go;
    logic       pulse;
    logic       blank;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    checks_cnt = 0;
  int    errors_cnt = 0;

  // Reference active-low 7-segment table.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'b1000000;
      4'd1: seg7 = 7'b1111001;
      4'd2: seg7 = 7'b0100100;
      4'd3: seg7 = 7'b0110000;
      4'd4: seg7 = 7'b0011001;
      4'd5: seg7 = 7'b0010010;
      4'd6: seg7 = 7'b0000010;
      4'd7: seg7 = 7'b1111000;
      4'd8: seg7 = 7'b0000000;
      4'd9: seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  function automatic logic [13:0] exp_hex(input logic [7:0] v, input logic blank);
    if (blank) exp_hex = 14'h3FFF;
    else       exp_hex = {seg7(v[7:4]), seg7(v[3:0])};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks_cnt++;
    if (got !== want) begin
      errors_cnt++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic expect_out(input string tag, input logic [7:0] v,
                            input logic go, input logic pl, input logic blank);
    exp_t e;
    e.value = v;
    e.go    = go;
    e.pulse = pl;
    e.blank = blank;
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_out();
    exp_t  e;
    string t;
    check_eq("sb_depth", 32'(sb_q.size()), 32'd1);
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    $display("txn %s value=%h go=%b pulse=%b hex=%h", t, value_bcd,
             game_over_signal, expired_pulse, hex);
    check_eq({t, ".value"}, 32'(value_bcd), 32'(e.value));
    check_eq({t, ".go"},    32'(game_over_signal), 32'(e.go));
    check_eq({t, ".pulse"}, 32'(expired_pulse), 32'(e.pulse));
    check_eq({t, ".hex"},   32'(hex), 32'(exp_hex(e.value, e.blank)));
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b0; pause = 1'b0; bonus = 1'b0;

    // Reset state, then idle ignores pause and bonus.
    expect_out("reset", 8'h12, 0, 0, 0);        cycles(2);  check_out();
    rst = 1'b1; pause = 1'b1; bonus = 1'b1;
    expect_out("idle_ignore", 8'h12, 0, 0, 0);  cycles(5);  check_out();
    pause = 1'b0; bonus = 1'b0;

    // Run 1: plain countdown, warning blink, expiry, blinking in EXPIRED.
    start = 1'b1;
    expect_out("start", 8'h12, 0, 0, 0);        cycles(1);  check_out();
    start = 1'b0;
    expect_out("pre_tick", 8'h12, 0, 0, 0);     cycles(7);  check_out();
    expect_out("tick1", 8'h11, 0, 0, 0);        cycles(1);  check_out();
    expect_out("tick2", 8'h10, 0, 0, 0);        cycles(8);  check_out();
    expect_out("borrow", 8'h09, 0, 0, 0);       cycles(8);  check_out();
    expect_out("warn_above", 8'h04, 0, 0, 0);   cycles(44); check_out();
    expect_out("warn_show", 8'h03, 0, 0, 0);    cycles(4);  check_out();
    expect_out("warn_blank4", 8'h03, 0, 0, 1);  cycles(4);  check_out();
    expect_out("warn_blank7", 8'h03, 0, 0, 1);  cycles(3);  check_out();
    expect_out("warn_next", 8'h02, 0, 0, 0);    cycles(1);  check_out();
    expect_out("pre_expire", 8'h01, 0, 0, 1);   cycles(15); check_out();
    expect_out("expire", 8'h00, 1, 1, 0);       cycles(1);  check_out();
    expect_out("expire_hold", 8'h00, 1, 0, 0);  cycles(1);  check_out();
    expect_out("exp_blank", 8'h00, 1, 0, 1);    cycles(3);  check_out();
    pause = 1'b1;
    expect_out("exp_show", 8'h00, 1, 0, 0);     cycles(4);  check_out();
    pause = 1'b0;

    // Restart from EXPIRED, then pause / resume divider behaviour.
    start = 1'b1;
    expect_out("restart", 8'h12, 0, 0, 0);      cycles(1);  check_out();
    start = 1'b0;
    expect_out("run_05", 8'h05, 0, 0, 0);       cycles(58); check_out();
    pause = 1'b1;
    expect_out("pause_edge", 8'h05, 0, 0, 0);   cycles(1);  check_out();
    pause = 1'b0;
    expect_out("paused_hold", 8'h05, 0, 0, 0);  cycles(100); check_out();
    pause = 1'b1;
    expect_out("resume", 8'h05, 0, 0, 0);       cycles(1);  check_out();
    pause = 1'b0;
    expect_out("resume_k4", 8'h05, 0, 0, 0);    cycles(4);  check_out();
    expect_out("resume_tick", 8'h04, 0, 0, 0);  cycles(1);  check_out();
    expect_out("run_02_blank", 8'h02, 0, 0, 1); cycles(20); check_out();
    pause = 1'b1;
    expect_out("paused_02", 8'h02, 0, 0, 0);    cycles(1);  check_out();
    pause = 1'b0;
    expect_out("paused_02_hold", 8'h02, 0, 0, 0); cycles(10); check_out();

    // pause+start together: PAUSED -> RUN with reload, then RUN -> PAUSED.
    pause = 1'b1; start = 1'b1;
    expect_out("ps_in_paused", 8'h12, 0, 0, 0); cycles(1);  check_out();
    expect_out("ps_in_run", 8'h12, 0, 0, 0);    cycles(1);  check_out();
    pause = 1'b0; start = 1'b0;
    expect_out("ps_hold", 8'h12, 0, 0, 0);      cycles(20); check_out();

    // Bonus while paused, saturating at 99.
    bonus = 1'b1;
    expect_out("bonus_97", 8'h97, 0, 0, 0);     cycles(17); check_out();
    expect_out("bonus_sat", 8'h99, 0, 0, 0);    cycles(1);  check_out();
    expect_out("bonus_sat_hold", 8'h99, 0, 0, 0); cycles(1); check_out();
    bonus = 1'b0;

    // Reset in the middle of a count overrides all other inputs.
    start = 1'b1;
    expect_out("restart2", 8'h12, 0, 0, 0);     cycles(1);  check_out();
    start = 1'b0;
    expect_out("run_07", 8'h07, 0, 0, 0);       cycles(43); check_out();
    rst = 1'b0; start = 1'b1; pause = 1'b1; bonus = 1'b1;
    expect_out("reset_mid", 8'h12, 0, 0, 0);    cycles(1);  check_out();
    rst = 1'b1; start = 1'b0;
    expect_out("idle_after_rst", 8'h12, 0, 0, 0); cycles(20); check_out();
    pause = 1'b0; bonus = 1'b0;

    // Bonus on the final tick: 01 - 1 + 5 = 05, no expiry.
    start = 1'b1;
    expect_out("start3", 8'h12, 0, 0, 0);       cycles(1);  check_out();
    start = 1'b0;
    expect_out("at_01", 8'h01, 0, 0, 1);        cycles(95); check_out();
    bonus = 1'b1;
    expect_out("bonus_tick", 8'h05, 0, 0, 0);   cycles(1);  check_out();
    bonus = 1'b0;
    expect_out("after_bonus", 8'h04, 0, 0, 0);  cycles(8);  check_out();

    $display("Result: errors=%0d of %0d checks", errors_cnt, checks_cnt);
    $finish;
  end

endmodule
